dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder for the RV32I core's load/store port.
//   - Accepts one load or store request at a time over a valid/ready handshake.
//   - Performs the byte, halfword or word access on an internal word array.
//   - Returns read data and an error flag over a second valid/ready handshake.
//   - Decodes funct3 with load_funct3_t / store_funct3_t from enum_pkg.
// PARAMETERS
//   DEPTH_WORDS  1024      number of 32-bit words in the array (power of 2)
//   WAIT_STATES  1         extra access cycles before response, 0..15
//   BASE_ADDR    32'h0     byte address of word 0
// PORTS
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   req_valid   in   1   request present
//   req_ready   out  1   request can be accepted
//   req_we      in   1   1 = store, 0 = load
//   req_funct3  in   3   load_funct3_t when req_we=0, store_funct3_t when req_we=1
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
//   rsp_valid   out  1   response present
//   rsp_ready   in   1   consumer takes the response
//   rsp_rdata   out  32  load result, already sign- or zero-extended; 0 for stores and errors
//   rsp_err     out  1   misaligned address, out-of-range address or illegal funct3
// BEHAVIOUR
//   Reset (async, rst=1)
//   - state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//   - Array contents are not reset.
//   - An uncommitted pending store is dropped; an unconsumed response is discarded.
//   FSM states: IDLE, BUSY, RESP
//   - req_ready = (state==IDLE). No acceptance in BUSY or RESP; one request outstanding.
//   - IDLE: on req_valid && req_ready, latch we/funct3/addr/wdata.
//     WAIT_STATES==0 -> go to RESP. Otherwise load counter=WAIT_STATES-1 and go to BUSY.
//   - BUSY: decrement counter; at 0 go to RESP.
//   - Entry edge into RESP does all of the following:
//     commit the store, read the array, register rsp_rdata/rsp_err, set rsp_valid=1.
//   - RESP: rsp_valid, rsp_rdata and rsp_err stay stable until rsp_ready=1.
//     On that edge: rsp_valid=0 and go to IDLE.
//   Timing
//   - rsp_valid rises WAIT_STATES+1 cycles after the accept edge.
//   - Minimum request spacing is WAIT_STATES+2 cycles.
//   - rsp_ready already high when rsp_valid rises -> response completes in that one cycle.
//   Decode
//   - off = req_addr - BASE_ADDR; word index = off[31:2].
//   - Out of range if off >= DEPTH_WORDS*4 (unsigned).
//   - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
//   - Illegal funct3: loads 3'b011, 3'b110, 3'b111; stores any value > 3'b010.
//   - Any error -> no array write, rsp_rdata=0, rsp_err=1.
//   Store
//   - SB writes lane addr[1:0] from wdata[7:0].
//   - SH writes lanes {addr[1],0} and {addr[1],1} from wdata[15:0].
//   - SW writes all four lanes.
//   - Unselected lanes are unchanged.
//   Load
//   - Extract the lane(s) selected by addr.
//   - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes through.
// TESTING
//   1. SW 0x10 = 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0.
//      rsp_valid must rise exactly WAIT_STATES+1 cycles after the accept edge.
//   2. SB 0x13 = 0x80. Then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080;
//      LW 0x10 -> 0x80ADBEEF.
//   3. LH 0x11 -> err 1, rdata 0. SW 0x12 -> err 1; a later LW 0x10 shows no change.
//   4. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata/err stable, req_ready 0,
//      and a req_valid pulse is not accepted.
//   5. Assert rst while a SW 0x20 = 0x12345678 is in BUSY -> all outputs at reset values.
//      A later LW 0x20 returns the value that was there before the store.
//   6. LW at BASE_ADDR + DEPTH_WORDS*4 -> err 1. Load with funct3 3'b011 -> err 1.
//      Back-to-back requests with rsp_ready tied high -> accepts every WAIT_STATES+2 cycles.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
// Both channels use valid/ready: a beat transfers on a rising edge where valid && ready; the sender holds valid and its payload stable until then.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding byte/halfword/word load or store on a word array,
// answered after WAIT_STATES extra cycles with extended read data and an error flag.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    output logic [1:0]       dbg_state
);
    // Same encodings as load_funct3_t / store_funct3_t in enum_pkg.
    typedef enum logic [2:0] {
        LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101
    } load_funct3_t;
    typedef enum logic [2:0] {
        SB = 3'b000, SH = 3'b001, SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic        rsp_valid_q, err_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept, enter_resp;
    logic             a_we;
    logic [2:0]       a_f3;
    logic [31:0]      a_addr, a_wdata, off, word, acc_rdata, wd;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [7:0]       sel_b;
    logic [15:0]      sel_h;
    logic [3:0]       be;
    logic             acc_err;

    assign accept     = bus.req_valid && (state == IDLE);
    assign enter_resp = !rst && ((accept && (WAIT_STATES == 0)) || (state == BUSY && cnt == 4'd0));

    // With zero wait states the access happens on the accept edge, straight from the bus.
    assign a_we    = (state == IDLE) ? bus.req_we     : we_q;
    assign a_f3    = (state == IDLE) ? bus.req_funct3 : f3_q;
    assign a_addr  = (state == IDLE) ? bus.req_addr   : addr_q;
    assign a_wdata = (state == IDLE) ? bus.req_wdata  : wdata_q;

    assign off   = a_addr - BASE_ADDR;
    assign idx   = off[IDX_W+1:2];
    assign lane  = a_addr[1:0];
    assign word  = mem[idx];
    assign sel_b = word[{lane, 3'b000} +: 8];
    assign sel_h = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        acc_err   = 1'b0;
        acc_rdata = 32'h0;
        be        = 4'b0000;
        wd        = 32'h0;
        if (a_we) begin
            case (store_funct3_t'(a_f3))
                SB: begin
                    be = 4'b0001 << lane;
                    wd = {4{a_wdata[7:0]}};
                end
                SH: begin
                    acc_err = lane[0];
                    be      = lane[1] ? 4'b1100 : 4'b0011;
                    wd      = {2{a_wdata[15:0]}};
                end
                SW: begin
                    acc_err = (lane != 2'b00);
                    be      = 4'b1111;
                    wd      = a_wdata;
                end
                default: acc_err = 1'b1;
            endcase
        end else begin
            case (load_funct3_t'(a_f3))
                LB:  acc_rdata = {{24{sel_b[7]}}, sel_b};
                LBU: acc_rdata = {24'h0, sel_b};
                LH: begin
                    acc_err   = lane[0];
                    acc_rdata = {{16{sel_h[15]}}, sel_h};
                end
                LHU: begin
                    acc_err   = lane[0];
                    acc_rdata = {16'h0, sel_h};
                end
                LW: begin
                    acc_err   = (lane != 2'b00);
                    acc_rdata = word;
                end
                default: acc_err = 1'b1;
            endcase
        end
        if ({1'b0, off} >= SPAN) acc_err = 1'b1;
        if (acc_err || a_we) begin
            acc_rdata = 32'h0;
        end
        if (acc_err) be = 4'b0000;
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: if (accept) begin
                if (WAIT_STATES == 0) begin
                    state_d = RESP;
                end else begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) state_d = RESP;
                else             cnt_d   = cnt - 4'd1;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rdata_q     <= acc_rdata;
                err_q       <= acc_err;
            end else if (state == RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // Array is deliberately not reset; only enabled lanes change.
    always_ff @(posedge clk) begin
        if (enter_resp) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// loads/stores checked against a byte-array reference model.
module tb_dmem_responder;
    localparam int          WS    = 1;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [7:0]  ref_mem [DEPTH*4];
    logic [31:0] exp_q [$];

    // Reference: size and signedness from funct3, then plain byte-array arithmetic.
    function automatic void model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int          size;
        bit          legal, uns;
        logic [31:0] off, v, mask;
        size = 1; legal = 1'b1; uns = 1'b0;
        off  = addr - BASE;
        if (we) begin
            if (f3 <= 3'd2) size = 1 << f3; else legal = 1'b0;
        end else begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                3'd4: begin size = 1; uns = 1'b1; end
                3'd5: begin size = 2; uns = 1'b1; end
                default: legal = 1'b0;
            endcase
        end
        er = !legal || (addr % size != 0) || (off >= DEPTH * 4);
        rd = 32'h0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[off + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            if (!uns && size < 4 && v[8*size-1]) v = v | ~mask;
            rd = v;
        end
    endfunction

    // Starts and ends on a falling edge with the DUT idle; lat = -1 on timeout.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.rsp_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) lat = -1;
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: valid=%b rdata=%h err=%b ready=%b, required 0/00000000/0/1",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
        end
    endtask

    task automatic test_init();
        logic [31:0] rd, erd, wd;
        logic        er, eer;
        int          lat;
        for (int w = 0; w < 18; w++) begin
            wd = $urandom;
            model_op(1'b1, 3'd2, 32'(w * 4), wd, erd, eer);
            do_req(1'b1, 3'd2, 32'(w * 4), wd, rd, er, lat);
            n_vec++;
            if (er !== eer || rd !== erd || lat != WS + 1) begin
                n_fail++;
                $display("FAIL init_sw[%0d]: err=%b rdata=%h lat=%0d, required err=%b rdata=%h lat=%0d",
                         w, er, rd, lat, eer, erd, WS + 1);
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat;
        model_op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, erd, eer);
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat);
        n_vec++;
        if (er !== 1'b0 || rd !== 32'h0 || lat != WS + 1) begin
            n_fail++;
            $display("FAIL sw_word: err=%b rdata=%h lat=%0d, required 0 00000000 %0d", er, rd, lat, WS + 1);
        end
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        n_vec++;
        if (er !== 1'b0 || rd !== 32'hDEADBEEF || lat != WS + 1) begin
            n_fail++;
            $display("FAIL lw_word: err=%b rdata=%h lat=%0d, required 0 deadbeef %0d", er, rd, lat, WS + 1);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd, erd, want [3];
        logic [2:0]  f3s [3];
        logic [31:0] addrs [3];
        logic        er, eer;
        int          lat;
        model_op(1'b1, 3'd0, 32'h13, 32'h80, erd, eer);
        do_req(1'b1, 3'd0, 32'h13, 32'h80, rd, er, lat);
        n_vec++;
        if (er !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_0x13: err=%b, required 0", er);
        end
        f3s   = '{3'd0, 3'd4, 3'd2};
        addrs = '{32'h13, 32'h13, 32'h10};
        want  = '{32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, f3s[i], addrs[i], 32'h0, rd, er, lat);
            n_vec++;
            if (er !== 1'b0 || rd !== want[i]) begin
                n_fail++;
                $display("FAIL byte_load[%0d]: err=%b rdata=%h, required 0 %h", i, er, rd, want[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat;
        logic        wes   [5];
        logic [2:0]  f3s   [5];
        logic [31:0] addrs [5];
        wes   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        f3s   = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
        addrs = '{32'h11, 32'h12, BASE + 32'(DEPTH * 4), 32'h10, 32'h10};
        for (int i = 0; i < 5; i++) begin
            model_op(wes[i], f3s[i], addrs[i], 32'hCAFEF00D, erd, eer);
            do_req(wes[i], f3s[i], addrs[i], 32'hCAFEF00D, rd, er, lat);
            n_vec++;
            if (er !== 1'b1 || rd !== 32'h0) begin
                n_fail++;
                $display("FAIL error_case[%0d]: err=%b rdata=%h, required 1 00000000", i, er, rd);
            end
        end
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        n_vec++;
        if (er !== 1'b0 || rd !== 32'h80ADBEEF) begin
            n_fail++;
            $display("FAIL no_write_on_err: err=%b rdata=%h, required 0 80adbeef", er, rd);
        end
    endtask

    task automatic test_hold();
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat;
        model_op(1'b0, 3'd1, 32'h12, 32'h0, erd, eer);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd1;
        bus.req_addr   = 32'h12;
        bus.rsp_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'hAAAA5555;
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== erd || bus.rsp_err !== eer || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: valid=%b rdata=%h err=%b ready=%b, required 1 %h %b 0",
                         c, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, erd, eer);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: valid=%b ready=%b, required 0 1", bus.rsp_valid, bus.req_ready);
        end
        model_op(1'b0, 3'd2, 32'h30, 32'h0, erd, eer);
        do_req(1'b0, 3'd2, 32'h30, 32'h0, rd, er, lat);
        n_vec++;
        if (er !== eer || rd !== erd) begin
            n_fail++;
            $display("FAIL hold_no_accept: err=%b rdata=%h, required %b %h", er, rd, eer, erd);
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'h12345678;
        bus.rsp_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: valid=%b rdata=%h err=%b ready=%b, required 0/00000000/0/1",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_op(1'b0, 3'd2, 32'h20, 32'h0, erd, eer);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
        n_vec++;
        if (er !== eer || rd !== erd) begin
            n_fail++;
            $display("FAIL dropped_store: err=%b rdata=%h, required %b %h", er, rd, eer, erd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wd;
        logic        er, eer, we;
        logic [2:0]  f3;
        int          lat;
        for (int n = 0; n < 80; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255))
                                               : BASE + 32'($urandom_range(0, 71));
            wd   = $urandom;
            model_op(we, f3, addr, wd, erd, eer);
            do_req(we, f3, addr, wd, rd, er, lat);
            n_vec++;
            if (er !== eer || rd !== erd || lat != WS + 1) begin
                n_fail++;
                $display("FAIL random[%0d] we=%b f3=%0d addr=%h: err=%b rdata=%h lat=%0d, required %b %h %0d",
                         n, we, f3, addr, er, rd, lat, eer, erd, WS + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] erd;
        logic        eer;
        int          acc_q [$];
        int          got;
        model_op(1'b0, 3'd2, 32'h10, 32'h0, erd, eer);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h10;
        bus.rsp_ready  = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.rsp_valid) begin
                got = exp_q.size();
                n_vec++;
                if (got == 0 || bus.rsp_rdata !== exp_q[0] || bus.rsp_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_rsp cyc %0d: rdata=%h err=%b pending=%0d, required %h 0",
                             cyc, bus.rsp_rdata, bus.rsp_err, got, erd);
                end
                if (got != 0) void'(exp_q.pop_front());
            end
            if (cyc == 39) bus.req_valid = 1'b0;
            if (bus.req_valid && bus.req_ready) begin
                acc_q.push_back(cyc);
                exp_q.push_back(erd);
            end
            @(posedge clk);
            @(negedge clk);
        end
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            if (bus.rsp_valid) begin
                n_vec++;
                if (bus.rsp_rdata !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL b2b_drain: rdata=%h, required %h", bus.rsp_rdata, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        n_vec++;
        if (exp_q.size() != 0 || acc_q.size() < 10) begin
            n_fail++;
            $display("FAIL b2b_count: pending=%0d accepts=%0d, required 0 and at least 10",
                     exp_q.size(), acc_q.size());
        end
        for (int i = 1; i < acc_q.size(); i++) begin
            n_vec++;
            if (acc_q[i] - acc_q[i-1] != WS + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: %0d cycles, required %0d", i, acc_q[i] - acc_q[i-1], WS + 2);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b1;
        for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_init();
        test_word();
        test_byte();
        test_errors();
        test_hold();
        test_reset_busy();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
